// File: rtl/base_qual_for_n_pkg.sv
// Shared definitions for the level qualifier: state encodings and a
// saturating-increment helper reused by any saturating counter.
package base_qual_for_n_pkg;

  typedef enum logic [1:0] {
    S_LO = 2'd0,
    S_QR = 2'd1,
    S_HI = 2'd2,
    S_QF = 2'd3
  } qual_state_e;

  // Returns value+1, or value unchanged once it reaches the all-ones
  // maximum of a counter that is 'width' bits wide (width 1..32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/base_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment
// on the same edge so software never sees a stale count after clearing.
module base_sat_cnt
  import base_qual_for_n_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [width-1:0] count
);

  // Count events, hold at all-ones, clear on request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= width'(sat_inc(32'(count), width));
    end
  end

endmodule

// File: rtl/base_qual_for_n.sv
// Level qualifier: o_d adopts a new i_d level only after it has been
// sampled n times in a row; shorter excursions are dropped and counted.
module base_qual_for_n
  import base_qual_for_n_pkg::*;
#(
  parameter int n  = 2,
  parameter int cw = $clog2(n + 1),
  parameter int gw = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_d,
  input  logic          i_clr_glitch,
  output logic          o_d,
  output logic          o_rise,
  output logic          o_fall,
  output logic          o_qual,
  output logic [gw-1:0] o_glitch_cnt
);

  localparam logic [cw-1:0] last_cnt = cw'(n - 1);

  qual_state_e   state;
  logic [cw-1:0] cnt;
  logic          glitch_evt;

  // A candidate transition that loses its level before completing is a glitch.
  always_comb begin
    glitch_evt = ((state == S_QR) && !i_d) || ((state == S_QF) && i_d);
  end

  // Qualification FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_LO;
      cnt    <= '0;
      o_d    <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      o_qual <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      case (state)
        S_LO: begin
          if (i_d) begin
            if (n == 1) begin
              state  <= S_HI;
              o_d    <= 1'b1;
              o_rise <= 1'b1;
            end else begin
              state  <= S_QR;
              cnt    <= cw'(1);
              o_qual <= 1'b1;
            end
          end
        end
        S_QR: begin
          if (i_d) begin
            if (cnt == last_cnt) begin
              state  <= S_HI;
              cnt    <= '0;
              o_d    <= 1'b1;
              o_rise <= 1'b1;
              o_qual <= 1'b0;
            end else begin
              cnt <= cnt + cw'(1);
            end
          end else begin
            state  <= S_LO;
            cnt    <= '0;
            o_qual <= 1'b0;
          end
        end
        S_HI: begin
          if (!i_d) begin
            if (n == 1) begin
              state  <= S_LO;
              o_d    <= 1'b0;
              o_fall <= 1'b1;
            end else begin
              state  <= S_QF;
              cnt    <= cw'(1);
              o_qual <= 1'b1;
            end
          end
        end
        S_QF: begin
          if (!i_d) begin
            if (cnt == last_cnt) begin
              state  <= S_LO;
              cnt    <= '0;
              o_d    <= 1'b0;
              o_fall <= 1'b1;
              o_qual <= 1'b0;
            end else begin
              cnt <= cnt + cw'(1);
            end
          end else begin
            state  <= S_HI;
            cnt    <= '0;
            o_qual <= 1'b0;
          end
        end
        default: begin
          state  <= S_LO;
          cnt    <= '0;
          o_d    <= 1'b0;
          o_qual <= 1'b0;
        end
      endcase
    end
  end

  base_sat_cnt #(
    .width(gw)
  ) u_glitch_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (glitch_evt),
    .clr  (i_clr_glitch),
    .count(o_glitch_cnt)
  );

endmodule

// File: tb/tb_base_qual_for_n.sv
// Bench for the level qualifier: an n=4 and an n=1 instance are driven in
// parallel; a run-length reference model predicts each edge's outputs into
// queues which a monitor drains and compares.
module tb_base_qual_for_n;

  localparam int GW = 8;
  localparam int GMAX = (1 << GW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic d4 = 1'b0, clr4 = 1'b0, d1 = 1'b0, clr1 = 1'b0;
  logic o_d4, o_rise4, o_fall4, o_qual4;
  logic o_d1, o_rise1, o_fall1, o_qual1;
  logic [GW-1:0] g4, g1;

  int checks = 0;
  int fails = 0;

  typedef struct {
    logic d;
    int   run;
    int   glitch;
  } model_t;

  typedef struct {
    logic          d;
    logic          rise;
    logic          fall;
    logic          qual;
    logic [GW-1:0] g;
  } exp_t;

  model_t m4, m1;
  exp_t   q4[$];
  exp_t   q1[$];

  base_qual_for_n #(.n(4), .gw(GW)) dut4 (
    .clk(clk), .reset(reset), .i_d(d4), .i_clr_glitch(clr4),
    .o_d(o_d4), .o_rise(o_rise4), .o_fall(o_fall4), .o_qual(o_qual4),
    .o_glitch_cnt(g4)
  );

  base_qual_for_n #(.n(1), .gw(GW)) dut1 (
    .clk(clk), .reset(reset), .i_d(d1), .i_clr_glitch(clr1),
    .o_d(o_d1), .o_rise(o_rise1), .o_fall(o_fall1), .o_qual(o_qual1),
    .o_glitch_cnt(g1)
  );

  always #5 clk = ~clk;

  // Reference: count consecutive samples that differ from the accepted level.
  function automatic void model_step(inout model_t m, input int n,
                                     input logic din, input logic clr,
                                     output exp_t e);
    bit glitch;
    glitch = 0;
    e.rise = 1'b0;
    e.fall = 1'b0;
    if (din != m.d) begin
      m.run++;
      if (m.run == n) begin
        if (din) e.rise = 1'b1;
        else     e.fall = 1'b1;
        m.d   = din;
        m.run = 0;
      end
    end else begin
      if (m.run > 0) glitch = 1;
      m.run = 0;
    end
    if (clr) m.glitch = 0;
    else if (glitch && m.glitch < GMAX) m.glitch++;
    e.d    = m.d;
    e.qual = (m.run > 0);
    e.g    = GW'(m.glitch);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reset_model();
    m4 = '{d: 1'b0, run: 0, glitch: 0};
    m1 = '{d: 1'b0, run: 0, glitch: 0};
    q4.delete();
    q1.delete();
  endtask

  // Predict expected outputs for each clock edge taken out of reset.
  always @(posedge clk) begin
    exp_t e;
    if (!reset) begin
      model_step(m4, 4, d4, clr4, e);
      q4.push_back(e);
      model_step(m1, 1, d1, clr1, e);
      q1.push_back(e);
    end
  end

  // Monitor: compare DUT outputs just after each edge against the queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      if (q4.size() == 0) begin
        checkOutput("n4 queue underflow", 32'd0, 32'd1);
      end else begin
        e = q4.pop_front();
        checkOutput("n4 o_d", 32'(o_d4), 32'(e.d));
        checkOutput("n4 o_rise", 32'(o_rise4), 32'(e.rise));
        checkOutput("n4 o_fall", 32'(o_fall4), 32'(e.fall));
        checkOutput("n4 o_qual", 32'(o_qual4), 32'(e.qual));
        checkOutput("n4 glitch_cnt", 32'(g4), 32'(e.g));
      end
      if (q1.size() == 0) begin
        checkOutput("n1 queue underflow", 32'd0, 32'd1);
      end else begin
        e = q1.pop_front();
        checkOutput("n1 o_d", 32'(o_d1), 32'(e.d));
        checkOutput("n1 o_rise", 32'(o_rise1), 32'(e.rise));
        checkOutput("n1 o_fall", 32'(o_fall1), 32'(e.fall));
        checkOutput("n1 o_qual", 32'(o_qual1), 32'(e.qual));
        checkOutput("n1 glitch_cnt", 32'(g1), 32'(e.g));
      end
    end
  end

  task automatic applyStimulus(input logic v4, input logic c4,
                               input logic v1, input logic c1);
    @(negedge clk);
    d4   = v4;
    clr4 = c4;
    d1   = v1;
    clr1 = c1;
  endtask

  task automatic drive4(input logic v4, input logic c4, input int edges);
    for (int i = 0; i < edges; i++) applyStimulus(v4, c4, ~d1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, " n4 o_d"}, 32'(o_d4), 32'd0);
    checkOutput({tag, " n4 o_qual"}, 32'(o_qual4), 32'd0);
    checkOutput({tag, " n4 o_rise"}, 32'(o_rise4), 32'd0);
    checkOutput({tag, " n4 o_fall"}, 32'(o_fall4), 32'd0);
    checkOutput({tag, " n4 glitch"}, 32'(g4), 32'd0);
    checkOutput({tag, " n1 o_d"}, 32'(o_d1), 32'd0);
  endtask

  // Assert reset mid-cycle, check outputs clear at once, release on negedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    reset_model();
    #1;
    check_all_zero(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic lvl;
    int   run_left;
    reset_model();
    #3;
    check_all_zero("power-on reset");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] rise and strobe");
    drive4(1'b1, 1'b0, 6);

    $display("[TB] fall with one-cycle abort");
    drive4(1'b0, 1'b0, 2);
    drive4(1'b1, 1'b0, 1);
    drive4(1'b0, 1'b0, 5);

    $display("[TB] short pulse rejected");
    drive4(1'b1, 1'b0, 3);
    drive4(1'b0, 1'b0, 3);

    $display("[TB] glitch counter saturation");
    for (int i = 0; i < 300; i++) begin
      drive4(1'b1, 1'b0, 3);
      drive4(1'b0, 1'b0, 1);
    end
    drive4(1'b1, 1'b0, 3);
    drive4(1'b0, 1'b1, 1);
    drive4(1'b1, 1'b0, 3);
    drive4(1'b0, 1'b0, 2);

    $display("[TB] randomized runs");
    run_left = 0;
    lvl = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (run_left == 0) begin
        lvl      = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 6);
      end
      run_left--;
      applyStimulus(lvl, ($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] reset during qualification");
    drive4(1'b1, 1'b0, 5);
    drive4(1'b0, 1'b0, 2);
    do_reset("reset in fall qual");
    drive4(1'b1, 1'b0, 2);
    do_reset("reset in rise qual");
    drive4(1'b1, 1'b0, 6);
    drive4(1'b0, 1'b0, 6);

    @(negedge clk);
    @(negedge clk);
    checkOutput("n4 queue drained", 32'(q4.size()), 32'd0);
    checkOutput("n1 queue drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
